// File: rtl/ulpb_ctrl_if.sv
// ULPB ring-side signal bundle for the bus controller.
// master: the clock-generating controller. slave: the ring / member side.
interface ulpb_ctrl_if;
    logic       CLKIN;        // bus clock returning from the last ring member
    logic       DIN;          // bus data returning from the last ring member
    logic       FORCE_INT;    // local request to terminate the current message
    logic       CLKOUT;       // bus clock driven into the ring
    logic       DOUT;         // bus data driven into the ring
    logic       BUS_BUSY;     // controller is not idle
    logic       MSG_DONE;     // one-cycle pulse on return to idle
    logic [1:0] MSG_CTRL;     // {control bit 0, control bit 1} of the last message
    logic       MSG_TIMEOUT;  // last message ended on a bit-count timeout

    modport master (
        input  CLKIN,
        input  DIN,
        input  FORCE_INT,
        output CLKOUT,
        output DOUT,
        output BUS_BUSY,
        output MSG_DONE,
        output MSG_CTRL,
        output MSG_TIMEOUT
    );

    modport slave (
        output CLKIN,
        output DIN,
        output FORCE_INT,
        input  CLKOUT,
        input  DOUT,
        input  BUS_BUSY,
        input  MSG_DONE,
        input  MSG_CTRL,
        input  MSG_TIMEOUT
    );
endinterface

// File: rtl/ulpb_ctrl.sv
// ULPB ring bus controller.
// Idle: bus clock parked high. A member pulling DIN low starts a message;
// the controller then divides CLK into the bus clock, forwards ring data,
// closes the message with the interrupt pattern (member request, local
// FORCE_INT or bit-count timeout), clocks two control bits and goes idle.
module ulpb_ctrl #(
    parameter int CLK_DIV        = 4,     // CLK cycles per bus-clock half period (>= 4)
    parameter int MAX_BIT_CYCLES = 1024,  // bus-clock rises per message before timeout
    parameter int CNT_W          = 16     // bit counter width, 2^CNT_W > MAX_BIT_CYCLES
) (
    input  logic        CLK,
    input  logic        RESET,
    ulpb_ctrl_if.master bus
);

    localparam int                PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACTIVE,
        S_INT_DRIVE,
        S_CTRL0,
        S_CTRL1,
        S_BACK_IDLE
    } state_t;

    // Synchronizer stages, bit 1 = CLKIN, bit 0 = DIN
    logic [1:0]       r_sync_meta;
    logic [1:0]       r_sync;
    logic [1:0]       w_async_in;
    logic             w_din_s;
    logic             w_clkin_s;

    // Controller state and registered outputs
    state_t           r_state;
    logic [PH_W-1:0]  r_phase;
    logic [1:0]       r_seg;         // INT_DRIVE segment (4 segments of CLK_DIV cycles)
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_clkout;
    logic             r_dout;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_ctrl;        // published control bits
    logic [1:0]       r_ctrl_cap;    // control bits captured during the current message
    logic             r_timeout;     // published timeout flag
    logic             r_to_pend;     // timeout flag of the current message

    // Cycle qualifiers and interrupt trigger terms
    logic             w_wrap;
    logic             w_member_req;
    logic             w_bit_limit;
    logic             w_trigger;
    logic             w_timeout_only;

    assign w_async_in = {bus.CLKIN, bus.DIN};
    assign w_clkin_s  = r_sync[1];
    assign w_din_s    = r_sync[0];

    // The phase counter wraps on the last cycle of each half period; with
    // CLKOUT high that is the "last high cycle" where decisions are taken.
    assign w_wrap         = (r_phase == PH_LAST);
    assign w_member_req   = ~w_clkin_s;
    assign w_bit_limit    = (r_bit_cnt >= MAX_CNT);
    assign w_trigger      = w_member_req | bus.FORCE_INT | w_bit_limit;
    // Timeout is reported only when nothing else asked for the interrupt
    assign w_timeout_only = w_bit_limit & ~w_member_req & ~bus.FORCE_INT;

    // Two-flop synchronizers for the ring return signals; park at the idle level
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync_meta <= 2'b11;
            r_sync      <= 2'b11;
        end else begin
            r_sync_meta <= w_async_in;
            r_sync      <= r_sync_meta;
        end
    end

    // Message sequencer: bus clock generation, data forwarding, interrupt
    // pattern, control-bit capture and completion reporting
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_seg      <= 2'd0;
            r_bit_cnt  <= '0;
            r_clkout   <= 1'b1;
            r_dout     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ctrl     <= 2'b00;
            r_ctrl_cap <= 2'b00;
            r_timeout  <= 1'b0;
            r_to_pend  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Phase runs continuously whenever a message is in progress
            if (r_state != S_IDLE) begin
                r_phase <= w_wrap ? '0 : r_phase + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_clkout <= 1'b1;
                    r_dout   <= 1'b1;
                    if (!w_din_s) begin
                        r_state <= S_START;
                        r_phase <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                // One extra high half period announces the message
                S_START: begin
                    if (w_wrap) begin
                        r_clkout <= 1'b0;
                        r_dout   <= w_din_s;
                        r_state  <= S_ACTIVE;
                    end
                end

                S_ACTIVE: begin
                    if (w_wrap) begin
                        if (!r_clkout) begin
                            // Rising edge: count the bit, saturate at all ones
                            r_clkout <= 1'b1;
                            if (r_bit_cnt != '1) begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else if (w_trigger) begin
                            // Keep the clock high and start the interrupt pattern
                            r_state   <= S_INT_DRIVE;
                            r_seg     <= 2'd0;
                            r_dout    <= 1'b1;
                            r_to_pend <= w_timeout_only;
                        end else begin
                            // Falling edge: forward the ring data
                            r_clkout <= 1'b0;
                            r_dout   <= w_din_s;
                        end
                    end
                end

                // DOUT 1,0,1,0 with the clock held high, then release the clock
                S_INT_DRIVE: begin
                    if (w_wrap) begin
                        if (r_seg == 2'd3) begin
                            r_clkout <= 1'b0;
                            r_dout   <= w_din_s;
                            r_state  <= S_CTRL0;
                        end else begin
                            r_seg  <= r_seg + 2'd1;
                            r_dout <= ~r_dout;
                        end
                    end
                end

                // Control bits: sampled on the last high cycle, forwarded on the fall
                S_CTRL0, S_CTRL1: begin
                    if (w_wrap) begin
                        if (!r_clkout) begin
                            r_clkout <= 1'b1;
                        end else begin
                            r_clkout <= 1'b0;
                            if (r_state == S_CTRL0) begin
                                r_ctrl_cap[1] <= w_din_s;
                                r_dout        <= w_din_s;
                                r_state       <= S_CTRL1;
                            end else begin
                                r_ctrl_cap[0] <= w_din_s;
                                r_dout        <= 1'b1;
                                r_state       <= S_BACK_IDLE;
                            end
                        end
                    end
                end

                // Last bus period with DOUT high; the clock stays high into IDLE
                S_BACK_IDLE: begin
                    r_dout <= 1'b1;
                    if (w_wrap) begin
                        if (!r_clkout) begin
                            r_clkout <= 1'b1;
                        end else begin
                            r_state   <= S_IDLE;
                            r_phase   <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_ctrl    <= r_ctrl_cap;
                            r_timeout <= r_to_pend;
                            r_bit_cnt <= '0;
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_clkout <= 1'b1;
                    r_dout   <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CLKOUT      = r_clkout;
    assign bus.DOUT        = r_dout;
    assign bus.BUS_BUSY    = r_busy;
    assign bus.MSG_DONE    = r_done;
    assign bus.MSG_CTRL    = r_ctrl;
    assign bus.MSG_TIMEOUT = r_timeout;

endmodule

// File: tb/tb_ulpb_ctrl.sv
// Directed bench for ulpb_ctrl: CLK_DIV=4, MAX_BIT_CYCLES=64, CLKIN looped
// back from CLKOUT. Expected message results go into a queue when a
// message is provoked; a monitor pops one entry per MSG_DONE pulse.
module tb_ulpb_ctrl;

    localparam int CLK_DIV  = 4;
    localparam int MAX_BITS = 64;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    logic clkin_low = 1'b0;

    ulpb_ctrl_if bus();

    assign bus.CLKIN = clkin_low ? 1'b0 : bus.CLKOUT;

    ulpb_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .MAX_BIT_CYCLES (MAX_BITS),
        .CNT_W          (16)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] ctrl;
        logic       to;
    } done_t;

    done_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    logic  prev_clk  = 1'b1;
    logic  saw_rise  = 1'b0;
    logic  saw_fall  = 1'b0;
    logic  dout_at_rise = 1'b0;
    int    rise_cnt  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Advance one cycle and classify CLKOUT edges (samples on the falling CLK edge)
    task automatic step();
        @(negedge CLK);
        saw_rise = bus.CLKOUT && !prev_clk;
        saw_fall = !bus.CLKOUT && prev_clk;
        prev_clk = bus.CLKOUT;
        if (saw_rise) begin
            rise_cnt++;
            dout_at_rise = bus.DOUT;
        end
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!saw_fall && n < 60);
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.BUS_BUSY && n < 30);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.MSG_DONE && n < 60);
    endtask

    task automatic wait_rise(input int target, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (saw_rise && rise_cnt == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // From a rise sample, count high cycles up to the fall and record DOUT over
    // the 16 interrupt-pattern cycles (the 5th..20th high samples)
    task automatic high_run(output int n, output logic [15:0] pat);
        n   = 1;
        pat = '0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (saw_fall) break;
            n++;
            if (n >= 5 && n <= 20) pat = {pat[14:0], bus.DOUT};
            if (n == 5) begin
                clkin_low     = 1'b0;
                bus.FORCE_INT = 1'b0;
            end
        end
    endtask

    // CTRL0 / CTRL1 / BACK_IDLE with the given control bits, ending on MSG_DONE
    task automatic finish_msg(input logic c0, input logic c1, input string tag);
        int n;
        bus.DIN = c0;
        wait_fall(n);
        check({tag, "_ctrl0_period"}, n, 8);
        bus.DIN = c1;
        wait_fall(n);
        check({tag, "_ctrl1_period"}, n, 8);
        bus.DIN = 1'b1;
        wait_done(n);
        check({tag, "_done_latency"}, n, 8);
        check({tag, "_idle_busy"}, bus.BUS_BUSY, 0);
        check({tag, "_idle_clkout"}, bus.CLKOUT, 1);
        check({tag, "_idle_dout"}, bus.DOUT, 1);
        step();
        check({tag, "_done_pulse"}, bus.MSG_DONE, 0);
        check({tag, "_ctrl_held"}, bus.MSG_CTRL, {c0, c1});
    endtask

    task automatic start_msg(input string tag);
        int n;
        rise_cnt = 0;
        bus.DIN  = 1'b0;
        wait_busy(n);
        check({tag, "_start_busy"}, n, 3);
        bus.DIN  = 1'b1;
    endtask

    // Scoreboard monitor: every MSG_DONE must match the oldest expectation
    initial begin
        done_t e;
        forever begin
            @(negedge CLK);
            if (bus.MSG_DONE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got MSG_DONE=1 expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    check("done_msg_ctrl", bus.MSG_CTRL, e.ctrl);
                    check("done_msg_timeout", bus.MSG_TIMEOUT, e.to);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic        ok;
        logic [15:0] pat;
        logic        prev_exp;
        logic [3:0]  fwd_pat;

        bus.DIN       = 1'b0;
        bus.FORCE_INT = 1'b0;

        // Reset values with DIN low
        repeat (3) step();
        check("rst_clkout", bus.CLKOUT, 1);
        check("rst_dout", bus.DOUT, 1);
        check("rst_busy", bus.BUS_BUSY, 0);
        check("rst_done", bus.MSG_DONE, 0);
        check("rst_ctrl", bus.MSG_CTRL, 0);
        check("rst_timeout", bus.MSG_TIMEOUT, 0);

        // Release: first CLKOUT fall 7 cycles later
        RESET    = 1'b0;
        rise_cnt = 0;
        wait_fall(n);
        check("start_first_fall", n, 7);
        check("start_busy", bus.BUS_BUSY, 1);

        // Forwarding 1,0,1,1: DOUT follows on the next fall, holds on the rise
        fwd_pat  = 4'b1011;
        prev_exp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.DIN = fwd_pat[3 - i];
            wait_fall(n);
            check("fwd_period", n, 8);
            check("fwd_dout_at_rise", dout_at_rise, prev_exp);
            check("fwd_dout", bus.DOUT, fwd_pat[3 - i]);
            prev_exp = fwd_pat[3 - i];
        end
        bus.DIN = 1'b1;

        // Member interrupt at the 40th rise
        wait_rise(40, ok);
        check("member_rise40", ok, 1);
        exp_q.push_back('{ctrl: 2'b10, to: 1'b0});
        clkin_low = 1'b1;
        high_run(n, pat);
        check("member_high_len", n, 20);
        check("member_int_pattern", pat, 16'hF0F0);
        finish_msg(1'b1, 1'b0, "member");

        // FORCE_INT while idle does nothing
        bus.FORCE_INT = 1'b1;
        repeat (20) step();
        check("idle_force_busy", bus.BUS_BUSY, 0);
        check("idle_force_clkout", bus.CLKOUT, 1);
        bus.FORCE_INT = 1'b0;

        // Timeout as sole trigger at the 64th rise
        start_msg("tmo");
        wait_rise(MAX_BITS, ok);
        check("tmo_rise64", ok, 1);
        exp_q.push_back('{ctrl: 2'b01, to: 1'b1});
        high_run(n, pat);
        check("tmo_high_len", n, 20);
        check("tmo_int_pattern", pat, 16'hF0F0);
        finish_msg(1'b0, 1'b1, "tmo");

        // FORCE_INT together with the bit limit: one sequence, no timeout flag
        start_msg("sim");
        wait_rise(MAX_BITS, ok);
        check("sim_rise64", ok, 1);
        exp_q.push_back('{ctrl: 2'b11, to: 1'b0});
        bus.FORCE_INT = 1'b1;
        high_run(n, pat);
        check("sim_high_len", n, 20);
        check("sim_int_pattern", pat, 16'hF0F0);
        finish_msg(1'b1, 1'b1, "sim");
        repeat (40) step();
        check("sim_no_restart", bus.BUS_BUSY, 0);

        // Reset in the middle of INT_DRIVE
        start_msg("rmid");
        wait_rise(10, ok);
        check("rmid_rise10", ok, 1);
        bus.FORCE_INT = 1'b1;
        repeat (4) step();
        bus.FORCE_INT = 1'b0;
        repeat (5) step();
        check("rmid_int_clkout", bus.CLKOUT, 1);
        check("rmid_int_dout", bus.DOUT, 0);
        bus.DIN = 1'b0;
        RESET   = 1'b1;
        #1;
        check("rmid_clkout", bus.CLKOUT, 1);
        check("rmid_dout", bus.DOUT, 1);
        check("rmid_busy", bus.BUS_BUSY, 0);
        check("rmid_done", bus.MSG_DONE, 0);
        check("rmid_ctrl", bus.MSG_CTRL, 0);
        check("rmid_timeout", bus.MSG_TIMEOUT, 0);
        repeat (3) step();
        RESET    = 1'b0;
        rise_cnt = 0;
        wait_fall(n);
        check("rmid_restart_fall", n, 7);
        repeat (10) step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
